float_to_fixed_pipe: RTL and testbench

Pipelined, parametrised IEEE-754 single-precision to signed fixed-point converter with valid/ready handshakes on both sides. It sits in front of the CORDIC datapath and replaces the combinational float-to-fixed unpacker. It adds a configurable output format, per-transaction truncate/round mode, saturation, and status flags.

---
 rtl/float_fmt_pkg.sv | 31 +++
 rtl/float_to_fixed_pipe_if.sv | 30 +++
 rtl/fixed_round_sat.sv | 55 +++++
 rtl/float_to_fixed_pipe.sv | 140 ++++++++++++++
 tb/tb_float_to_fixed_pipe.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/float_fmt_pkg.sv
// Shared IEEE-754 single-precision field layout, class encoding and status flag
// positions used by the float-to-fixed conversion pipeline.
package float_fmt_pkg;

  localparam int SIGN_W   = 1;
  localparam int EXP_W    = 8;
  localparam int MANT_W   = 23;
  localparam int EXP_BIAS = 127;
  localparam int FLOAT_W  = SIGN_W + EXP_W + MANT_W;
  localparam int SIG_W    = MANT_W + 1;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_DENORM,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } fclass_e;

  localparam int FLAG_OVF = 0;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_NAN = 2;
  localparam int FLAG_W   = 3;

  function automatic fclass_e classify(input logic [EXP_W-1:0] e, input logic [MANT_W-1:0] m);
    if (e == '0) return (m == '0) ? CLS_ZERO : CLS_DENORM;
    if (e == '1) return (m == '0) ? CLS_INF : CLS_NAN;
    return CLS_NORM;
  endfunction

endpackage

// File: rtl/float_to_fixed_pipe_if.sv
// Valid/ready bundle for the float-to-fixed converter: float words in, fixed-point
// results plus status flags out.
interface float_to_fixed_pipe_if
  import float_fmt_pkg::*;
#(
  parameter int OUT_W = 24
) ();

  logic               in_valid;
  logic               in_ready;
  logic [FLOAT_W-1:0] in_data;
  logic               in_round;
  logic               out_valid;
  logic               out_ready;
  logic [OUT_W-1:0]   out_data;
  logic               out_ovf;
  logic               out_unf;
  logic               out_nan;

  modport slave (
    input  in_valid, in_data, in_round, out_ready,
    output in_ready, out_valid, out_data, out_ovf, out_unf, out_nan
  );

  modport master (
    output in_valid, in_data, in_round, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, out_unf, out_nan
  );

endinterface

// File: rtl/fixed_round_sat.sv
// Final conversion step: rounds the shifted magnitude, saturates to the output
// range, applies the sign and derives the status flags. Purely combinational.
module fixed_round_sat
  import float_fmt_pkg::*;
#(
  parameter int OUT_W = 24
) (
  input  fclass_e           cls,
  input  logic              sign,
  input  logic              round_en,
  input  logic              big,
  input  logic [OUT_W-1:0]  mag,
  input  logic              guard,
  input  logic              sticky,
  output logic [OUT_W-1:0]  data,
  output logic [FLAG_W-1:0] flags
);

  localparam logic [OUT_W:0]   LIM     = (OUT_W+1)'(1) << (OUT_W-1);
  localparam logic [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_NEG = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] ONE     = OUT_W'(1);

  logic             inc;
  logic [OUT_W:0]   magr;
  logic [OUT_W-1:0] neg;

  always_comb begin
    inc   = round_en & guard & (sticky | mag[0]);
    magr  = {1'b0, mag} + {{OUT_W{1'b0}}, inc};
    neg   = ~magr[OUT_W-1:0] + ONE;
    data  = '0;
    flags = '0;
    case (cls)
      CLS_NORM: begin
        // A negative magnitude of exactly 2^(OUT_W-1) is the minimum code itself.
        if (big || (magr > LIM) || (magr == LIM && !sign)) begin
          data            = sign ? MIN_NEG : MAX_POS;
          flags[FLAG_OVF] = 1'b1;
        end else begin
          data            = sign ? neg : magr[OUT_W-1:0];
          flags[FLAG_UNF] = (magr == '0);
        end
      end
      CLS_INF: begin
        data            = sign ? MIN_NEG : MAX_POS;
        flags[FLAG_OVF] = 1'b1;
      end
      CLS_NAN:    flags[FLAG_NAN] = 1'b1;
      CLS_DENORM: flags[FLAG_UNF] = 1'b1;
      default:    ;
    endcase
  end

endmodule

// File: rtl/float_to_fixed_pipe.sv
// Three-stage IEEE-754 single to signed fixed-point converter with elastic
// valid/ready handshaking; stages advance independently so bubbles collapse.
module float_to_fixed_pipe
  import float_fmt_pkg::*;
#(
  parameter int OUT_W  = 24,
  parameter int FRAC_W = 22
) (
  input  logic                  clk,
  input  logic                  reset_n,
  float_to_fixed_pipe_if.slave  bus
);

  localparam logic signed [9:0] SHIFT_OFS = 10'(FRAC_W - EXP_BIAS);
  localparam logic signed [9:0] SIG_TOP   = 10'(MANT_W);
  // Left shifts at or beyond this put the leading one at bit OUT_W or higher.
  localparam logic signed [9:0] BIG_LSH   = 10'(OUT_W - MANT_W);
  localparam int RW = 2 * SIG_W + 1;

  logic en1, en2, en3;

  logic                v1_reg, sign1_reg, round1_reg;
  fclass_e             cls1_reg;
  logic [MANT_W-1:0]   man1_reg;
  logic signed [9:0]   shift1_reg;

  logic                v2_reg, sign2_reg, round2_reg, big2_reg, guard2_reg, sticky2_reg;
  fclass_e             cls2_reg;
  logic [OUT_W-1:0]    mag2_reg;

  logic                v3_reg;
  logic [OUT_W-1:0]    data3_reg;
  logic [FLAG_W-1:0]   flags3_reg;

  logic signed [9:0]   lsh, rsh;
  logic [3:0]          lamt;
  logic [5:0]          ramt;
  logic [RW-1:0]       rwide;
  logic [OUT_W-1:0]    mag_next;
  logic                big_next, guard_next, sticky_next;

  logic [OUT_W-1:0]    rs_data;
  logic [FLAG_W-1:0]   rs_flags;

  assign en3 = !v3_reg || bus.out_ready;
  assign en2 = !v2_reg || en3;
  assign en1 = !v1_reg || en2;
  assign bus.in_ready = en1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_reg     <= 1'b0;
      sign1_reg  <= 1'b0;
      round1_reg <= 1'b0;
      cls1_reg   <= CLS_ZERO;
      man1_reg   <= '0;
      shift1_reg <= '0;
    end else if (en1) begin
      v1_reg     <= bus.in_valid;
      sign1_reg  <= bus.in_data[FLOAT_W-1];
      round1_reg <= bus.in_round;
      cls1_reg   <= classify(bus.in_data[FLOAT_W-2:MANT_W], bus.in_data[MANT_W-1:0]);
      man1_reg   <= bus.in_data[MANT_W-1:0];
      shift1_reg <= $signed({2'b00, bus.in_data[FLOAT_W-2:MANT_W]}) + SHIFT_OFS;
    end
  end

  // Scaled magnitude = significand * 2^(shift - MANT_W).
  always_comb begin
    lsh         = shift1_reg - SIG_TOP;
    rsh         = SIG_TOP - shift1_reg;
    big_next    = (lsh >= BIG_LSH);
    lamt        = lsh[3:0];
    ramt        = (rsh > 10'sd25) ? 6'd25 : rsh[5:0];
    rwide       = {1'b1, man1_reg, {(SIG_W+1){1'b0}}} >> ramt;
    mag_next    = OUT_W'(rwide[RW-1:SIG_W+1]);
    guard_next  = rwide[SIG_W];
    sticky_next = |rwide[SIG_W-1:0];
    if (lsh >= 10'sd0) begin
      mag_next    = OUT_W'({1'b1, man1_reg}) << lamt;
      guard_next  = 1'b0;
      sticky_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v2_reg      <= 1'b0;
      sign2_reg   <= 1'b0;
      round2_reg  <= 1'b0;
      big2_reg    <= 1'b0;
      guard2_reg  <= 1'b0;
      sticky2_reg <= 1'b0;
      cls2_reg    <= CLS_ZERO;
      mag2_reg    <= '0;
    end else if (en2) begin
      v2_reg      <= v1_reg;
      sign2_reg   <= sign1_reg;
      round2_reg  <= round1_reg;
      big2_reg    <= big_next;
      guard2_reg  <= guard_next;
      sticky2_reg <= sticky_next;
      cls2_reg    <= cls1_reg;
      mag2_reg    <= mag_next;
    end
  end

  fixed_round_sat #(
    .OUT_W (OUT_W)
  ) u_round_sat (
    .cls      (cls2_reg),
    .sign     (sign2_reg),
    .round_en (round2_reg),
    .big      (big2_reg),
    .mag      (mag2_reg),
    .guard    (guard2_reg),
    .sticky   (sticky2_reg),
    .data     (rs_data),
    .flags    (rs_flags)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v3_reg     <= 1'b0;
      data3_reg  <= '0;
      flags3_reg <= '0;
    end else if (en3) begin
      v3_reg     <= v2_reg;
      data3_reg  <= rs_data;
      flags3_reg <= rs_flags;
    end
  end

  assign bus.out_valid = v3_reg;
  assign bus.out_data  = data3_reg;
  assign bus.out_ovf   = flags3_reg[FLAG_OVF];
  assign bus.out_unf   = flags3_reg[FLAG_UNF];
  assign bus.out_nan   = flags3_reg[FLAG_NAN];

endmodule

// File: tb/tb_float_to_fixed_pipe.sv
// Scoreboard bench for float_to_fixed_pipe (24/22): directed vectors, randomised
// backpressure against a reference model, and reset with words in flight.
module tb_float_to_fixed_pipe;

  localparam int OUT_W  = 24;
  localparam int FRAC_W = 22;
  localparam int NV     = 21;

  typedef struct {
    logic [31:0]      src;
    logic             rnd;
    logic [OUT_W-1:0] data;
    logic             ovf, unf, nan;
    int               cyc;
    bit               lat;
  } exp_t;

  typedef struct {
    logic [31:0] f;
    logic        r;
    logic [23:0] d;
    logic        o, u, n;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  float_to_fixed_pipe_if #(.OUT_W(OUT_W)) bus ();

  float_to_fixed_pipe #(
    .OUT_W  (OUT_W),
    .FRAC_W (FRAC_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  exp_t sb[$];
  exp_t cur;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   rdy_mode = 0;   // 0: out_ready=1, 1: random, 2: out_ready=0
  vec_t vecs[NV];

  task automatic chk(input bit ok, input string name, input string detail);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // Reference: exact integer remainder compared against half an LSB.
  function automatic exp_t model(input logic [31:0] f, input logic rnd);
    exp_t   r;
    longint mv, q, rem, half, lim;
    int     k, n;
    bit     big, up;
    r.src = f; r.rnd = rnd; r.data = '0; r.ovf = 0; r.unf = 0; r.nan = 0; r.cyc = 0; r.lat = 0;
    lim = longint'(1) << (OUT_W - 1);
    if (f[30:23] == 8'hff) begin
      if (f[22:0] != 0) r.nan = 1;
      else begin r.ovf = 1; r.data = f[31] ? OUT_W'(-lim) : OUT_W'(lim - 1); end
      return r;
    end
    if (f[30:23] == 8'h00) begin
      r.unf = (f[22:0] != 0);
      return r;
    end
    mv = longint'({1'b1, f[22:0]});
    k = int'(f[30:23]) - 150 + FRAC_W;
    big = 0; up = 0; q = 0;
    if (k >= 0) begin
      if (k > 20) big = 1; else q = mv << k;
    end else begin
      n = -k;
      if (n <= 40) begin
        q    = mv >> n;
        rem  = mv - (q << n);
        half = longint'(1) << (n - 1);
        up   = rnd && ((rem > half) || (rem == half && q[0]));
      end
    end
    if (up) q = q + 1;
    if (big || q > lim || (q == lim && !f[31])) begin
      r.ovf  = 1;
      r.data = f[31] ? OUT_W'(-lim) : OUT_W'(lim - 1);
    end else begin
      r.data = f[31] ? OUT_W'(-q) : OUT_W'(q);
      r.unf  = (q == 0);
    end
    return r;
  endfunction

  // Input-side tap: push the expected response on every accepted transfer.
  initial begin
    forever begin
      @(posedge clk);
      if (reset_n && bus.in_valid && bus.in_ready) begin
        exp_t e;
        e = cur;
        e.cyc = cyc;
        sb.push_back(e);
      end
      cyc++;
    end
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       bus.out_ready = ($urandom_range(0, 1) == 1);
        2:       bus.out_ready = 1'b0;
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  // Output monitor: ordering, values, latency, stall stability, full-pipe in_ready.
  initial begin
    bit               hold_v;
    logic [OUT_W-1:0] hold_d;
    logic [2:0]       hold_f;
    exp_t             e;
    hold_v = 0; hold_d = '0; hold_f = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        sb.delete();
        hold_v = 0;
      end else begin
        if (hold_v)
          chk({bus.out_valid, bus.out_data, bus.out_ovf, bus.out_unf, bus.out_nan} == {1'b1, hold_d, hold_f},
              "stall_stable", $sformatf("got v=%b d=%h f=%b%b%b want v=1 d=%h f=%b", bus.out_valid,
              bus.out_data, bus.out_ovf, bus.out_unf, bus.out_nan, hold_d, hold_f));
        if (sb.size() >= 3 && !bus.out_ready)
          chk(!bus.in_ready, "full_in_ready_low", $sformatf("got in_ready=%b want 0", bus.in_ready));
        if (bus.out_valid && sb.size() == 0) begin
          chk(0, "unexpected_out", $sformatf("got out_valid=1 d=%h want no output", bus.out_data));
        end else if (bus.out_valid && bus.out_ready) begin
          e = sb.pop_front();
          chk({bus.out_data, bus.out_ovf, bus.out_unf, bus.out_nan} == {e.data, e.ovf, e.unf, e.nan},
              "result", $sformatf("in=%h rnd=%b got d=%h o/u/n=%b%b%b want d=%h o/u/n=%b%b%b", e.src, e.rnd,
              bus.out_data, bus.out_ovf, bus.out_unf, bus.out_nan, e.data, e.ovf, e.unf, e.nan));
          if (e.lat)
            chk((cyc - e.cyc) == 3, "latency", $sformatf("in=%h got %0d cycles want 3", e.src, cyc - e.cyc));
          $display("[TB] in=%h rnd=%b -> out=%h ovf=%b unf=%b nan=%b", e.src, e.rnd, bus.out_data,
                   bus.out_ovf, bus.out_unf, bus.out_nan);
        end
        hold_v = bus.out_valid && !bus.out_ready;
        hold_d = bus.out_data;
        hold_f = {bus.out_ovf, bus.out_unf, bus.out_nan};
      end
    end
  end

  // Called at a negedge or at posedge+1; in_ready is stable one unit later.
  task automatic send(input logic [31:0] f, input logic r, input exp_t e);
    bit acc;
    int k;
    cur = e;
    bus.in_data  = f;
    bus.in_round = r;
    bus.in_valid = 1'b1;
    acc = 0;
    k = 0;
    while (!acc && k < 200) begin
      #1;
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      k++;
    end
    bus.in_valid = 1'b0;
    if (!acc) chk(0, "accept_timeout", $sformatf("in=%h got no accept in 200 cycles want accept", f));
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 300) begin
      @(posedge clk);
      k++;
    end
    if (sb.size() != 0) chk(0, "drain_timeout", $sformatf("got %0d pending want 0", sb.size()));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion want finish before 400000");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [31:0] f, m;
    logic [7:0]  ex;
    logic        r;

    vecs = '{
      '{32'h3f800000, 1'b0, 24'h400000, 1'b0, 1'b0, 1'b0},
      '{32'hbf800000, 1'b0, 24'hC00000, 1'b0, 1'b0, 1'b0},
      '{32'h3f000000, 1'b0, 24'h200000, 1'b0, 1'b0, 1'b0},
      '{32'hc0000000, 1'b0, 24'h800000, 1'b0, 1'b0, 1'b0},
      '{32'h40000000, 1'b0, 24'h7FFFFF, 1'b1, 1'b0, 1'b0},
      '{32'h3fffffff, 1'b0, 24'h7FFFFF, 1'b0, 1'b0, 1'b0},
      '{32'h3fffffff, 1'b1, 24'h7FFFFF, 1'b1, 1'b0, 1'b0},
      '{32'h34800000, 1'b0, 24'h000001, 1'b0, 1'b0, 1'b0},
      '{32'h34000000, 1'b0, 24'h000000, 1'b0, 1'b1, 1'b0},
      '{32'h34000000, 1'b1, 24'h000000, 1'b0, 1'b1, 1'b0},
      '{32'h34400000, 1'b1, 24'h000001, 1'b0, 1'b0, 1'b0},
      '{32'h34400000, 1'b0, 24'h000000, 1'b0, 1'b1, 1'b0},
      '{32'h33800000, 1'b1, 24'h000000, 1'b0, 1'b1, 1'b0},
      '{32'h00000001, 1'b1, 24'h000000, 1'b0, 1'b1, 1'b0},
      '{32'h7fc00000, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1},
      '{32'h7f800000, 1'b0, 24'h7FFFFF, 1'b1, 1'b0, 1'b0},
      '{32'hff800000, 1'b0, 24'h800000, 1'b1, 1'b0, 1'b0},
      '{32'h80000000, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0},
      '{32'h3f800001, 1'b1, 24'h400000, 1'b0, 1'b0, 1'b0},
      '{32'h3f800003, 1'b1, 24'h400002, 1'b0, 1'b0, 1'b0},
      '{32'hbf800003, 1'b1, 24'hBFFFFE, 1'b0, 1'b0, 1'b0}
    };

    reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_round = 1'b0;
    cur          = model(32'h0, 1'b0);
    #2;
    chk(bus.in_ready == 1'b1, "reset_in_ready", $sformatf("got %b want 1", bus.in_ready));
    chk({bus.out_valid, bus.out_data, bus.out_ovf, bus.out_unf, bus.out_nan} == '0, "reset_outputs",
        $sformatf("got v=%b d=%h f=%b%b%b want all 0", bus.out_valid, bus.out_data, bus.out_ovf,
        bus.out_unf, bus.out_nan));
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      e = model(vecs[i].f, vecs[i].r);
      e.data = vecs[i].d; e.ovf = vecs[i].o; e.unf = vecs[i].u; e.nan = vecs[i].n;
      e.lat = 1;
      send(vecs[i].f, vecs[i].r, e);
      drain();
    end

    rdy_mode = 1;
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      m  = $urandom;
      ex = 8'($urandom_range(98, 130));
      r  = 1'($urandom_range(0, 1));
      f  = {1'($urandom_range(0, 1)), ex, m[22:0]};
      send(f, r, model(f, r));
    end
    rdy_mode = 0;
    drain();

    rdy_mode = 2;
    @(posedge clk);
    #1;
    send(32'h3f800000, 1'b0, model(32'h3f800000, 1'b0));
    send(32'hbf000000, 1'b1, model(32'hbf000000, 1'b1));
    send(32'h3e800000, 1'b0, model(32'h3e800000, 1'b0));
    #1;
    chk(bus.in_ready == 1'b0, "three_held_in_ready", $sformatf("got %b want 0", bus.in_ready));
    chk(bus.out_valid == 1'b1, "three_held_out_valid", $sformatf("got %b want 1", bus.out_valid));
    reset_n = 1'b0;
    #1;
    chk(bus.out_valid == 1'b0, "async_reset_valid", $sformatf("got %b want 0", bus.out_valid));
    chk(bus.in_ready == 1'b1, "async_reset_in_ready", $sformatf("got %b want 1", bus.in_ready));
    chk(bus.out_data == '0, "async_reset_data", $sformatf("got %h want 000000", bus.out_data));
    repeat (2) @(posedge clk);
    rdy_mode = 0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    e = model(32'h3f000000, 1'b0);
    e.data = 24'h200000; e.ovf = 0; e.unf = 0; e.nan = 0; e.lat = 1;
    send(32'h3f000000, 1'b0, e);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
